// File: rtl/nibble_cpu_pkg.sv
// ---------------------------------------------------------------------------
// nibble_cpu_pkg
// Shared definitions for the nibble CPU core: FSM state encoding, opcode and
// addressing-mode values, register indices and a small decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package nibble_cpu_pkg;

  // Fetch three words, execute, optionally touch data memory, or stop.
  typedef enum logic [2:0] {
    ST_F0,
    ST_F1,
    ST_F2,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ST  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;

  localparam logic [1:0] MODE_IMM = 2'd0;
  localparam logic [1:0] MODE_DIR = 2'd1;
  localparam logic [1:0] MODE_IDX = 2'd2;
  localparam logic [1:0] MODE_NOP = 2'd3;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_X = 2'd1;
  localparam logic [1:0] REG_Y = 2'd2;
  localparam logic [1:0] REG_W = 2'd3;

  // Opcodes that produce a register result from an operand (LD counts as
  // an ALU pass-through of the operand).
  function automatic logic isAluOp(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/nibble_cpu_if.sv
// ---------------------------------------------------------------------------
// nibble_cpu_if
// Shared request/ready bus between the CPU core (master) and the memory
// system (slave). One bus carries both program fetches and data accesses.
//   req    master->slave  transfer request, fields stable until ready
//   space  master->slave  0 = program space, 1 = data space
//   addr   master->slave  PC_W+2 bit address
//   we     master->slave  1 = write
//   wdata  master->slave  store data (0 when we=0)
//   rdata  slave->master  read data, sampled when req & ready
//   ready  slave->master  completes the current transfer
// ---------------------------------------------------------------------------
interface nibble_cpu_if #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 10
);
  logic              req;
  logic              space;
  logic [PC_W+1:0]   addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, space, addr, we, wdata, input rdata, ready);
  modport slave  (input req, space, addr, we, wdata, output rdata, ready);
endinterface

// File: rtl/nibble_cpu_alu.sv
// ---------------------------------------------------------------------------
// nibble_cpu_alu
// Combinational ALU for the nibble CPU.
//   i_op      opcode (LD passes i_b through, ADD/AND/XOR combine i_a, i_b)
//   i_a       register operand
//   i_b       immediate or memory operand
//   o_result  DATA_W-bit result
//   o_z       result is zero
//   o_c       ADD carry-out; 0 for AND/XOR/LD (core decides whether to use it)
// ---------------------------------------------------------------------------
module nibble_cpu_alu
  import nibble_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_z,
  output logic              o_c
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Select the result; carry is only meaningful for ADD, the other ops
  // report a cleared carry.
  always_comb begin
    o_result = i_b;
    o_c      = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_c      = w_sum[DATA_W];
      end
      OP_AND: o_result = i_a & i_b;
      OP_XOR: o_result = i_a ^ i_b;
      default: o_result = i_b;
    endcase
  end

  assign o_z = (o_result == '0);

endmodule

// File: rtl/nibble_cpu_core.sv
// ---------------------------------------------------------------------------
// nibble_cpu_core
// Serial-fetch CPU: each instruction is three DATA_W-bit words fetched over
// one request/ready bus, then executed; loads/stores/memory-operand ALU ops
// take one extra data-space transfer.
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   bus       nibble_cpu_if master (req/space/addr/we/wdata out, rdata/ready in)
//   o_halted  1 while in the HALT state
//   o_dbg_pc  current program counter
// ---------------------------------------------------------------------------
module nibble_cpu_core
  import nibble_cpu_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int PC_W      = 10,
  parameter int NUM_REGS  = 3,
  parameter int JMP_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  nibble_cpu_if.master    bus,
  output logic            o_halted,
  output logic [PC_W-1:0] o_dbg_pc
);

  localparam int         ADDR_W = PC_W + 2;
  localparam logic [2:0] NREG   = 3'(NUM_REGS);

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_regs [4];
  logic                r_z;
  logic                r_c;
  logic [DATA_W-1:0]   r_w0;
  logic [DATA_W-1:0]   r_w1;
  logic [DATA_W-1:0]   r_w2;
  logic                r_req;
  logic                r_space;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_halted;

  logic [3:0]          w_op;
  logic [1:0]          w_dst;
  logic [1:0]          w_mode;
  logic [DATA_W-1:0]   w_opd;
  logic                w_dstOk;
  logic [DATA_W-1:0]   w_dstVal;
  logic [DATA_W-1:0]   w_ea;
  logic                w_nop;
  logic                w_memOp;
  logic [PC_W-1:0]     w_pcInc;
  logic [PC_W-1:0]     w_target;
  logic [PC_W-1:0]     w_pcNext;
  logic [DATA_W-1:0]   w_aluB;
  logic [DATA_W-1:0]   w_aluRes;
  logic                w_aluZ;
  logic                w_aluC;
  logic                w_wbEn;

  assign w_op     = r_w0[3:0];
  assign w_dst    = r_w1[3:2];
  assign w_mode   = r_w1[1:0];
  assign w_opd    = r_w2;

  // Registers beyond NUM_REGS do not exist: writes to them are dropped and
  // reads return zero.
  assign w_dstOk  = ({1'b0, w_dst} < NREG);
  assign w_dstVal = w_dstOk ? r_regs[w_dst] : '0;

  // X-indexed addressing wraps inside the DATA_W-bit data space.
  assign w_ea     = (w_mode == MODE_IDX) ? (w_opd + r_regs[REG_X]) : w_opd;

  assign w_nop    = (w_mode == MODE_NOP) || (w_op > OP_HLT);
  assign w_memOp  = (isAluOp(w_op) && (w_mode != MODE_IMM)) || (w_op == OP_ST);
  assign w_pcInc  = r_pc + PC_W'(1);
  assign w_target = PC_W'(w_opd) << JMP_SHIFT;

  // During MEM the operand is the word coming back on the bus; otherwise it
  // is the immediate from the third instruction word.
  assign w_aluB   = (r_state == ST_MEM) ? bus.rdata : w_opd;

  nibble_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (w_dstVal),
    .i_b      (w_aluB),
    .o_result (w_aluRes),
    .o_z      (w_aluZ),
    .o_c      (w_aluC)
  );

  // Next PC chosen in EXEC: taken jumps load the target, HLT holds the PC,
  // everything else (including untaken branches and NOPs) steps by one.
  always_comb begin
    w_pcNext = w_pcInc;
    if (!w_nop) begin
      case (w_op)
        OP_JMP: w_pcNext = w_target;
        OP_JZ:  w_pcNext = r_z ? w_target : w_pcInc;
        OP_JC:  w_pcNext = r_c ? w_target : w_pcInc;
        OP_HLT: w_pcNext = r_pc;
        default: w_pcNext = w_pcInc;
      endcase
    end
  end

  // A result is written either in EXEC for immediate operands or when the
  // memory operand arrives at the end of a read in MEM.
  assign w_wbEn = ((r_state == ST_EXEC) && !w_nop && isAluOp(w_op) && (w_mode == MODE_IMM)) ||
                  ((r_state == ST_MEM) && bus.ready && !r_we);

  // Register file and flags. LD only touches Z; AND/XOR clear C through the
  // ALU; flags update even when the destination register does not exist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else if (w_wbEn) begin
      if (w_dstOk) r_regs[w_dst] <= w_aluRes;
      r_z <= w_aluZ;
      if (w_op != OP_LD) r_c <= w_aluC;
    end
  end

  // Control FSM with registered bus outputs. Each fetch state waits for
  // ready, captures its word and presents the next address; EXEC is a single
  // bus-idle cycle that decides between the next fetch, a data transfer or
  // halting. Bus fields only change on a completed transfer, so they stay
  // stable across wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_F0;
      r_pc     <= '0;
      r_w0     <= '0;
      r_w1     <= '0;
      r_w2     <= '0;
      r_req    <= 1'b1;
      r_space  <= 1'b0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_F0: if (bus.ready) begin
          r_w0    <= bus.rdata;
          r_addr  <= {r_pc, 2'd1};
          r_state <= ST_F1;
        end
        ST_F1: if (bus.ready) begin
          r_w1    <= bus.rdata;
          r_addr  <= {r_pc, 2'd2};
          r_state <= ST_F2;
        end
        ST_F2: if (bus.ready) begin
          r_w2    <= bus.rdata;
          r_req   <= 1'b0;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_pc <= w_pcNext;
          if (!w_nop && (w_op == OP_HLT)) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (!w_nop && w_memOp) begin
            r_req   <= 1'b1;
            r_space <= 1'b1;
            r_addr  <= ADDR_W'(w_ea);
            r_we    <= (w_op == OP_ST);
            r_wdata <= (w_op == OP_ST) ? w_dstVal : '0;
            r_state <= ST_MEM;
          end else begin
            r_req   <= 1'b1;
            r_space <= 1'b0;
            r_addr  <= {w_pcNext, 2'd0};
            r_state <= ST_F0;
          end
        end
        ST_MEM: if (bus.ready) begin
          r_space <= 1'b0;
          r_we    <= 1'b0;
          r_wdata <= '0;
          r_addr  <= {r_pc, 2'd0};
          r_state <= ST_F0;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_F0;
      endcase
    end
  end

  assign bus.req   = r_req;
  assign bus.space = r_space;
  assign bus.addr  = r_addr;
  assign bus.we    = r_we;
  assign bus.wdata = r_wdata;
  assign o_halted  = r_halted;
  assign o_dbg_pc  = r_pc;

endmodule

// File: tb/tb_nibble_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_nibble_cpu_core
// Drives nibble_cpu_core with small directed programs and random ROM images
// through a ROM/RAM bus model. An instruction-level reference interpreter
// predicts every bus transfer; a monitor compares each completed transfer
// against that prediction and checks that stalled requests hold steady.
// ---------------------------------------------------------------------------
module tb_nibble_cpu_core;

  typedef struct packed {
    logic        space;
    logic [11:0] addr;
    logic        we;
    logic [3:0]  wdata;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halted;
  logic [9:0] dbgPc;

  logic [3:0] rom [4096];
  logic [3:0] ram [16];

  int    checks = 0;
  int    errors = 0;
  xfer_t expQ[$];
  int    readyMode = 0;
  int    stallLeft = 0;
  bit    stallDone = 1'b0;
  bit    pendValid = 1'b0;
  xfer_t pendX;
  int    writeCount = 0;

  int mReg [4];
  int mZ, mC, mPc, mHalted;
  int mRam [16];

  nibble_cpu_if #(.DATA_W(4), .PC_W(10)) bus ();

  nibble_cpu_core #(.DATA_W(4), .PC_W(10), .NUM_REGS(3), .JMP_SHIFT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .o_halted (halted),
    .o_dbg_pc (dbgPc)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Memory read path: program ROM or data RAM, selected by the address space.
  always_comb begin
    bus.rdata = bus.space ? ram[bus.addr[3:0]] : rom[bus.addr];
  end

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushXfer(input int space, input int addr, input int we, input int wdata);
    xfer_t x;
    x.space = 1'(space);
    x.addr  = 12'(addr);
    x.we    = 1'(we);
    x.wdata = 4'(wdata);
    expQ.push_back(x);
  endtask

  task automatic putInstr(input int pc, input int op, input int dst, input int mode, input int opd);
    rom[12'(pc * 4)]     = 4'(op);
    rom[12'(pc * 4 + 1)] = 4'(dst * 4 + mode);
    rom[12'(pc * 4 + 2)] = 4'(opd);
    rom[12'(pc * 4 + 3)] = 4'h0;
  endtask

  task automatic fillRom(input bit randomFill);
    for (int i = 0; i < 4096; i++) rom[i] = randomFill ? 4'($urandom) : 4'h9;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mReg[i] = 0;
    mZ = 0; mC = 0; mPc = 0; mHalted = 0;
    for (int i = 0; i < 16; i++) mRam[i] = int'(ram[i]);
  endtask

  // Instruction-level interpreter: executes up to maxInstr instructions and
  // records the bus transfers each one must produce.
  task automatic modelRun(input int maxInstr);
    int op, dst, mode, opd, ea, dv, operand, res, w1;
    for (int n = 0; n < maxInstr && mHalted == 0; n++) begin
      for (int i = 0; i < 3; i++) pushXfer(0, mPc * 4 + i, 0, 0);
      op   = int'(rom[12'(mPc * 4)]);
      w1   = int'(rom[12'(mPc * 4 + 1)]);
      opd  = int'(rom[12'(mPc * 4 + 2)]);
      dst  = w1 / 4;
      mode = w1 % 4;
      ea   = (mode == 2) ? (opd + mReg[1]) % 16 : opd;
      dv   = (dst < 3) ? mReg[dst] : 0;
      if (mode == 3 || op > 8) begin
        mPc = (mPc + 1) % 1024;
        continue;
      end
      case (op)
        0, 2, 3, 4: begin
          if (mode == 0) operand = opd;
          else begin
            pushXfer(1, ea, 0, 0);
            operand = mRam[4'(ea)];
          end
          res = operand;
          if (op == 2) begin
            res = (dv + operand) % 16;
            mC  = (dv + operand > 15) ? 1 : 0;
          end else if (op == 3) begin
            res = dv & operand; mC = 0;
          end else if (op == 4) begin
            res = dv ^ operand; mC = 0;
          end
          mZ = (res == 0) ? 1 : 0;
          if (dst < 3) mReg[dst] = res;
          mPc = (mPc + 1) % 1024;
        end
        1: begin
          pushXfer(1, ea, 1, dv);
          mRam[4'(ea)] = dv;
          mPc = (mPc + 1) % 1024;
        end
        5: mPc = (opd * 4) % 1024;
        6: mPc = (mZ != 0) ? (opd * 4) % 1024 : (mPc + 1) % 1024;
        7: mPc = (mC != 0) ? (opd * 4) % 1024 : (mPc + 1) % 1024;
        default: mHalted = 1;
      endcase
    end
  endtask

  // Assert reset a little after a rising edge and check the reset outputs.
  task automatic beginReset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expQ.delete();
    checkVal("rst req",   int'(bus.req), 1);
    checkVal("rst addr",  int'(bus.addr), 0);
    checkVal("rst space", int'(bus.space), 0);
    checkVal("rst we",    int'(bus.we), 0);
    checkVal("rst wdata", int'(bus.wdata), 0);
    checkVal("rst halted", int'(halted), 0);
    checkVal("rst pc",    int'(dbgPc), 0);
  endtask

  task automatic endReset();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Wait for every predicted transfer, then compare PC, halt state and RAM.
  task automatic waitDone(input string name);
    int cyc = 0;
    while (expQ.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    checkVal({name, " drained"}, expQ.size(), 0);
    repeat (3) @(negedge clk);
    checkVal({name, " pc"}, int'(dbgPc), mPc);
    checkVal({name, " halted"}, int'(halted), mHalted);
    if (mHalted != 0) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        checkVal({name, " halt req"}, int'(bus.req), 0);
        checkVal({name, " halt pc"}, int'(dbgPc), mPc);
      end
    end
    for (int i = 0; i < 16; i++)
      checkVal($sformatf("%s ram[%0d]", name, i), int'(ram[i]), mRam[i]);
  endtask

  // Bus ready generator: always ready, random wait states, or a 3-cycle
  // stall on each data-space transfer. Ready drops once the prediction
  // queue is exhausted so the core cannot run past the modelled program.
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() == 0) bus.ready = 1'b0;
      else if (readyMode == 0) bus.ready = 1'b1;
      else if (readyMode == 1) bus.ready = ($urandom_range(0, 3) != 0);
      else begin
        if (bus.req && bus.space) begin
          if (!stallDone) begin
            stallLeft = 3;
            stallDone = 1'b1;
          end
        end else stallDone = 1'b0;
        if (stallLeft > 0) begin
          bus.ready = 1'b0;
          stallLeft--;
        end else bus.ready = 1'b1;
      end
    end
  end

  // Monitor: on each falling edge, a held request must match its previous
  // value, and a completing transfer is compared with the next prediction.
  // Completed writes update the RAM model.
  initial begin
    xfer_t cur, expX;
    forever begin
      @(negedge clk);
      if (rst) pendValid = 1'b0;
      else if (bus.req) begin
        cur.space = bus.space;
        cur.addr  = bus.addr;
        cur.we    = bus.we;
        cur.wdata = bus.wdata;
        if (pendValid) checkVal("bus hold", int'(cur), int'(pendX));
        if (bus.ready) begin
          pendValid = 1'b0;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected xfer: got 0x%0h, expected none", cur);
          end else begin
            expX = expQ.pop_front();
            checkVal("xfer", int'(cur), int'(expX));
          end
          if (bus.we) begin
            ram[bus.addr[3:0]] = bus.wdata;
            writeCount++;
          end
        end else begin
          pendValid = 1'b1;
          pendX     = cur;
        end
      end else pendValid = 1'b0;
    end
  end

  task automatic applyStimulus();
    int found;

    // LD A,#5; ADD A,#C; ST A,[0]; JZ 7; JC 7 -> 28: HLT
    readyMode = 0;
    beginReset();
    fillRom(1'b0);
    for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
    putInstr(0, 0, 0, 0, 5);
    putInstr(1, 2, 0, 0, 12);
    putInstr(2, 1, 0, 1, 0);
    putInstr(3, 6, 0, 0, 7);
    putInstr(4, 7, 0, 0, 7);
    putInstr(28, 8, 0, 0, 0);
    modelReset();
    modelRun(40);
    endReset();
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkVal("lat exec req", int'(bus.req), 0);
    checkVal("lat exec pc", int'(dbgPc), 1);
    @(posedge clk);
    @(negedge clk);
    checkVal("lat done pc", int'(dbgPc), 2);
    checkVal("lat done addr", int'(bus.addr), 8);
    waitDone("addc");

    // ST A,[3] with the data transfer stalled for three cycles
    readyMode = 2;
    beginReset();
    fillRom(1'b0);
    for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
    putInstr(0, 0, 0, 0, 9);
    putInstr(1, 1, 0, 1, 3);
    putInstr(2, 8, 0, 0, 0);
    modelReset();
    modelRun(40);
    writeCount = 0;
    endReset();
    waitDone("stall");
    checkVal("stall writes", writeCount, 1);

    // LD X,#2; LD Y,[F]+X (wraps to 1); ST Y,[4]; HLT
    readyMode = 1;
    beginReset();
    fillRom(1'b0);
    for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
    putInstr(0, 0, 1, 0, 2);
    putInstr(1, 0, 2, 2, 15);
    putInstr(2, 1, 2, 1, 4);
    putInstr(3, 8, 0, 0, 0);
    modelReset();
    modelRun(40);
    endReset();
    waitDone("index");

    // XOR A,#0; JZ 7 -> 28: JC 7 (C=0) -> 29: HLT
    readyMode = 0;
    beginReset();
    fillRom(1'b0);
    putInstr(0, 4, 0, 0, 0);
    putInstr(1, 6, 0, 0, 7);
    putInstr(28, 7, 0, 0, 7);
    putInstr(29, 8, 0, 0, 0);
    modelReset();
    modelRun(40);
    endReset();
    waitDone("branch");

    // Reset during a stalled store must drop the write and clear all state
    readyMode = 2;
    beginReset();
    fillRom(1'b0);
    for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
    ram[5] = 4'hA;
    putInstr(0, 0, 0, 0, 7);
    putInstr(1, 1, 0, 1, 5);
    putInstr(2, 8, 0, 0, 0);
    modelReset();
    modelRun(40);
    writeCount = 0;
    endReset();
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (bus.req && bus.space && bus.we && !bus.ready) found = 1;
    end
    checkVal("abort stall seen", found, 1);
    beginReset();
    checkVal("abort writes", writeCount, 0);
    checkVal("abort ram[5]", int'(ram[5]), 10);
    readyMode = 0;
    fillRom(1'b0);
    putInstr(0, 1, 0, 1, 6);
    putInstr(1, 1, 1, 1, 7);
    putInstr(2, 1, 2, 1, 8);
    putInstr(3, 6, 0, 0, 5);
    putInstr(4, 7, 0, 0, 5);
    putInstr(5, 8, 0, 0, 0);
    putInstr(20, 8, 0, 0, 0);
    modelReset();
    modelRun(40);
    endReset();
    waitDone("abort");

    // Random ROM images with random wait states
    readyMode = 1;
    for (int t = 0; t < 8; t++) begin
      beginReset();
      fillRom(1'b1);
      for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
      modelReset();
      modelRun(25);
      endReset();
      waitDone($sformatf("rand%0d", t));
    end
  endtask

  task automatic checkOutput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

  // Global time limit so a stuck core cannot hang the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
